// File: rtl/atari_key_matrix.sv
// Keyboard-side responder for the POKEY scanner: key bitmap + modifiers answered on KR,
// with a minimum-press stretcher. Optional `KEY_MATRIX_CLEAR_EN adds the all_up clear input.
module atari_key_matrix #(
    parameter int MIN_FRAMES  = 2,
    parameter int IDLE_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef KEY_MATRIX_CLEAR_EN
    input  logic       all_up,
`endif
    input  logic       evt_valid,
    output logic       evt_ready,
    input  logic [1:0] evt_kind,
    input  logic [5:0] evt_code,
    input  logic       evt_make,
    input  logic [5:0] K,
    output logic [2:1] KR,
    output logic       scan_active
);

    localparam logic [3:0]  MIN_F  = 4'(MIN_FRAMES);
    localparam logic [15:0] IDLE_L = 16'(IDLE_CYCLES);

    typedef enum logic {ACCEPT, HOLD} state_t;

    state_t      state_q, state_d;
    logic        ready_q;
    logic [63:0] bitmap_q, bitmap_d;
    logic        shift_q, shift_d, ctrl_q, ctrl_d, brk_q, brk_d;
    logic [3:0]  age_q, age_d;
    logic [5:0]  last_q, last_d, hold_q, hold_d;
    logic [5:0]  k_q;
    logic [15:0] idle_q, idle_d;
    logic        scan_q, scan_d;
    logic [2:1]  kr_q, kr_d;
    logic        frame_tick, accept;

    assign frame_tick  = (k_q == 6'h3F) && (K == 6'h00);
    assign accept      = evt_valid && ready_q;
    assign evt_ready   = ready_q;
    assign scan_active = scan_q;
    assign KR          = kr_q;

    always_comb begin
        state_d  = state_q;
        bitmap_d = bitmap_q;
        shift_d  = shift_q;
        ctrl_d   = ctrl_q;
        brk_d    = brk_q;
        age_d    = age_q;
        last_d   = last_q;
        hold_d   = hold_q;
        idle_d   = idle_q;

        if (K != k_q)
            idle_d = 16'd0;
        else if (idle_q != 16'hFFFF)
            idle_d = idle_q + 16'd1;
        scan_d = (idle_d < IDLE_L);

        if (frame_tick && age_q != 4'hF)
            age_d = age_q + 4'd1;

        case (state_q)
            ACCEPT: begin
                if (accept) begin
                    case (evt_kind)
                        2'b01: shift_d = evt_make;
                        2'b10: ctrl_d  = evt_make;
                        2'b11: brk_d   = evt_make;
                        default: begin
                            if (evt_make) begin
                                bitmap_d[evt_code] = 1'b1;
                                last_d             = evt_code;
                                age_d              = 4'd0;
                            // A fresh tap of the last key is stretched until the scanner has seen it
                            end else if (evt_code == last_q && bitmap_q[evt_code] &&
                                         age_q < MIN_F && scan_q) begin
                                state_d = HOLD;
                                hold_d  = evt_code;
                            end else begin
                                bitmap_d[evt_code] = 1'b0;
                            end
                        end
                    endcase
                end
            end
            HOLD: begin
                if (age_q >= MIN_F || !scan_q) begin
                    bitmap_d[hold_q] = 1'b0;
                    state_d          = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase

`ifdef KEY_MATRIX_CLEAR_EN
        if (all_up) begin
            bitmap_d = '0;
            shift_d  = 1'b0;
            ctrl_d   = 1'b0;
            brk_d    = 1'b0;
            last_d   = last_q;
            hold_d   = hold_q;
            age_d    = 4'hF;
            state_d  = ACCEPT;
        end
`endif

        kr_d[1] = ~bitmap_q[K];
        kr_d[2] = ~(((K == 6'h3F) && ctrl_q) || ((K == 6'h2F) && shift_q) ||
                    ((K == 6'h0F) && brk_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ACCEPT;
            ready_q  <= 1'b0;
            bitmap_q <= '0;
            shift_q  <= 1'b0;
            ctrl_q   <= 1'b0;
            brk_q    <= 1'b0;
            age_q    <= 4'd0;
            last_q   <= 6'd0;
            hold_q   <= 6'd0;
            k_q      <= 6'd0;
            idle_q   <= 16'd0;
            scan_q   <= 1'b0;
            kr_q     <= 2'b11;
        end else begin
            state_q  <= state_d;
            ready_q  <= (state_d == ACCEPT);
            bitmap_q <= bitmap_d;
            shift_q  <= shift_d;
            ctrl_q   <= ctrl_d;
            brk_q    <= brk_d;
            age_q    <= age_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            k_q      <= K;
            idle_q   <= idle_d;
            scan_q   <= scan_d;
            kr_q     <= kr_d;
        end
    end

endmodule

// File: tb/tb_atari_key_matrix.sv
// Directed bench for atari_key_matrix: reset, key sweeps, press stretching, modifiers, clear.
module tb_atari_key_matrix;

    localparam int MINF = 2;
    localparam int IDLE = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       all_up;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_kind;
    logic [5:0] evt_code;
    logic       evt_make;
    logic [5:0] K;
    logic [2:1] KR;
    logic       scan_active;

    int checks = 0;
    int errors = 0;

    logic [63:0] kr1, kr2;
    logic [63:0] ones;
    logic [63:0] one;

    atari_key_matrix #(.MIN_FRAMES(MINF), .IDLE_CYCLES(IDLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef KEY_MATRIX_CLEAR_EN
        .all_up     (all_up),
`endif
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_kind   (evt_kind),
        .evt_code   (evt_code),
        .evt_make   (evt_make),
        .K          (K),
        .KR         (KR),
        .scan_active(scan_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(output logic [63:0] r1, output logic [63:0] r2);
        for (int a = 0; a < 64; a++) begin
            K = 6'(a);
            step();
            r1[a] = KR[1];
            r2[a] = KR[2];
        end
    endtask

    task automatic send(input logic [1:0] kind, input logic [5:0] code, input logic make);
        int n;
        evt_valid = 1'b1;
        evt_kind  = kind;
        evt_code  = code;
        evt_make  = make;
        n = 0;
        while (!evt_ready && n < 200) begin
            step();
            n++;
        end
        chk("send_rdy", 64'(evt_ready), 64'd1);
        step();
        evt_valid = 1'b0;
    endtask

    initial begin
        int n;
        ones = '1;
        one  = 64'd1;
        rst_n = 1'b0; all_up = 1'b0; evt_valid = 1'b0;
        evt_kind = 2'b00; evt_code = 6'd0; evt_make = 1'b0; K = 6'd0;
        repeat (3) step();
        chk("rst_kr",    64'(KR), 64'd3);
        chk("rst_ready", 64'(evt_ready), 64'd0);
        chk("rst_scan",  64'(scan_active), 64'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 64'(evt_ready), 64'd1);

        sweep(kr1, kr2); sweep(kr1, kr2);
        chk("idle_kr1", kr1, ones);
        chk("idle_kr2", kr2, ones);

        // Key 0x15 held for three frames, then released immediately
        send(2'b00, 6'h15, 1'b1);
        sweep(kr1, kr2);
        chk("k15_kr1", kr1, ~(one << 6'h15));
        chk("k15_kr2", kr2, ones);
        sweep(kr1, kr2); sweep(kr1, kr2);
        send(2'b00, 6'h15, 1'b0);
        chk("k15_rel_ready", 64'(evt_ready), 64'd1);
        sweep(kr1, kr2);
        chk("k15_gone", kr1, ones);

        // Short tap of 0x21 while scanning: stretched over frames
        send(2'b00, 6'h21, 1'b1);
        send(2'b00, 6'h21, 1'b0);
        chk("tap_hold_ready", 64'(evt_ready), 64'd0);
        sweep(kr1, kr2);
        chk("tap_f1_kr1", kr1, ~(one << 6'h21));
        chk("tap_f1_ready", 64'(evt_ready), 64'd0);
        sweep(kr1, kr2);
        chk("tap_f2_ready", 64'(evt_ready), 64'd1);
        chk("tap_f2_kr1", kr1, ones);

        // Same tap with the scan frozen: completes once scanning is declared stopped
        K = 6'h00;
        step();
        send(2'b00, 6'h21, 1'b1);
        send(2'b00, 6'h21, 1'b0);
        chk("frz_hold", 64'(evt_ready), 64'd0);
        n = 0;
        while (!evt_ready && n < 100) begin
            step();
            n++;
        end
        chk("frz_ready", 64'(evt_ready), 64'd1);
        chk("frz_scan", 64'(scan_active), 64'd0);
        send(2'b00, 6'h22, 1'b1);
        send(2'b00, 6'h22, 1'b0);
        chk("frz_nostall", 64'(evt_ready), 64'd1);
        sweep(kr1, kr2);
        chk("frz_kr1", kr1, ones);

        // Modifiers
        send(2'b01, 6'h00, 1'b1);
        send(2'b10, 6'h00, 1'b1);
        send(2'b11, 6'h00, 1'b1);
        sweep(kr1, kr2);
        chk("mod_all_kr2", kr2, ~((one << 6'h2F) | (one << 6'h3F) | (one << 6'h0F)));
        chk("mod_all_kr1", kr1, ones);
        send(2'b01, 6'h00, 1'b0);
        sweep(kr1, kr2);
        chk("mod_noshift", kr2, ~((one << 6'h3F) | (one << 6'h0F)));
        send(2'b10, 6'h00, 1'b0);
        send(2'b11, 6'h00, 1'b0);
        sweep(kr1, kr2);
        chk("mod_none", kr2, ones);

        // Two keys down; releasing the older one never stalls
        send(2'b00, 6'h05, 1'b1);
        send(2'b00, 6'h06, 1'b1);
        send(2'b00, 6'h05, 1'b0);
        chk("two_rel_ready", 64'(evt_ready), 64'd1);
        send(2'b01, 6'h00, 1'b1);
        sweep(kr1, kr2);
        chk("two_kr1", kr1, ~(one << 6'h06));
        chk("two_kr2", kr2, ~(one << 6'h2F));
        send(2'b00, 6'h06, 1'b0);
        chk("k06_hold", 64'(evt_ready), 64'd0);
`ifdef KEY_MATRIX_CLEAR_EN
        all_up = 1'b1;
        step();
        all_up = 1'b0;
        chk("allup_ready", 64'(evt_ready), 64'd1);
        sweep(kr1, kr2);
        chk("allup_kr1", kr1, ones);
        chk("allup_kr2", kr2, ones);
`else
        sweep(kr1, kr2);
        chk("k06_ready", 64'(evt_ready), 64'd1);
        send(2'b01, 6'h00, 1'b0);
        sweep(kr1, kr2);
        chk("k06_kr1", kr1, ones);
        chk("k06_kr2", kr2, ones);
`endif

        // Reset while a release is being held drops it
        send(2'b00, 6'h30, 1'b1);
        send(2'b00, 6'h30, 1'b0);
        chk("rh_hold", 64'(evt_ready), 64'd0);
        rst_n = 1'b0;
        step();
        chk("rh_rst_ready", 64'(evt_ready), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rh_ready", 64'(evt_ready), 64'd1);
        sweep(kr1, kr2);
        chk("rh_kr1", kr1, ones);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
